// File: rtl/spi_master_fifo.sv
// spi_master_fifo
//   SPI mode-0 master (MSB first) with a TX byte FIFO that feeds the shift
//   engine and an RX byte FIFO that collects received bytes.
//
//   Ports
//     raw_clk        single clock, all state on its rising edge
//     reset          asynchronous, active-high
//     tx_data/push   enqueue a byte; ignored while tx_full
//     tx_full        TX FIFO holds DEPTH entries
//     rx_data        show-ahead head of RX FIFO, valid when rx_empty=0
//     rx_pop         dequeue RX head; ignored while rx_empty
//     rx_empty       RX FIFO holds zero entries
//     rx_overflow    sticky: a received byte was dropped (RX full)
//     overflow_clear clears rx_overflow (a same-cycle new overflow wins)
//     busy           transfer in progress or TX FIFO non-empty
//     sclk/mosi/miso SPI bus
//
//   Engine states
//     state   | meaning
//     IDLE    | sclk low, mosi holds last bit, waiting for a TX byte
//     LOW     | sclk low for DIVIDER cycles, mosi carries current bit
//     HIGH    | sclk high for DIVIDER cycles, miso already sampled
module spi_master_fifo #(
   parameter int DIVIDER = 4,
   parameter int DEPTH   = 4
) (
   input  logic       raw_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_push,
   output logic       tx_full,
   output logic [7:0] rx_data,
   input  logic       rx_pop,
   output logic       rx_empty,
   output logic       rx_overflow,
   input  logic       overflow_clear,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [7:0]     PH_LAST  = 8'(DIVIDER - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   logic [1:0]       state;
   logic [7:0]       phase;
   logic [2:0]       bit_cnt;
   logic [7:0]       tx_shift;
   logic [7:0]       rx_shift;

   logic [7:0]       tx_mem [DEPTH];
   logic [PTR_W-1:0] tx_wr;
   logic [PTR_W-1:0] tx_rd;
   logic [PTR_W:0]   tx_cnt;

   logic [7:0]       rx_mem [DEPTH];
   logic [PTR_W-1:0] rx_wr;
   logic [PTR_W-1:0] rx_rd;
   logic [PTR_W:0]   rx_cnt;

   logic tx_push_ok;
   logic eng_load;
   logic eng_done;
   logic rx_pop_ok;
   logic rx_push_ok;
   logic ovf_set;

   assign tx_full    = (tx_cnt == FULL_CNT);
   assign rx_empty   = (rx_cnt == '0);
   assign rx_data    = rx_mem[rx_rd];
   assign busy       = (state != ST_IDLE) || (tx_cnt != '0);

   assign tx_push_ok = tx_push && !tx_full;
   assign eng_load   = (state == ST_IDLE) && (tx_cnt != '0);
   assign eng_done   = (state == ST_HIGH) && (phase == PH_LAST) && (bit_cnt == 3'd7);
   assign rx_pop_ok  = rx_pop && !rx_empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign rx_push_ok = eng_done && ((rx_cnt != FULL_CNT) || rx_pop_ok);
   assign ovf_set    = eng_done && !rx_push_ok;

   // Shift engine
   always_ff @(posedge raw_clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         phase    <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (eng_load) begin
                  tx_shift <= tx_mem[tx_rd];
                  mosi     <= tx_mem[tx_rd][7];
                  phase    <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (phase == PH_LAST) begin
                  phase    <= '0;
                  sclk     <= 1'b1;
                  rx_shift <= {rx_shift[6:0], miso};
                  state    <= ST_HIGH;
               end else begin
                  phase <= phase + 8'd1;
               end
            end
            ST_HIGH: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
                  sclk  <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_IDLE;
                  end else begin
                     tx_shift <= {tx_shift[6:0], 1'b0};
                     mosi     <= tx_shift[6];
                     bit_cnt  <= bit_cnt + 3'd1;
                     state    <= ST_LOW;
                  end
               end else begin
                  phase <= phase + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // TX FIFO
   always_ff @(posedge raw_clk or posedge reset) begin
      if (reset) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
      end else begin
         if (tx_push_ok) begin
            tx_mem[tx_wr] <= tx_data;
            tx_wr         <= tx_wr + PTR_W'(1);
         end
         if (eng_load) tx_rd <= tx_rd + PTR_W'(1);
         case ({tx_push_ok, eng_load})
            2'b10:   tx_cnt <= tx_cnt + (PTR_W+1)'(1);
            2'b01:   tx_cnt <= tx_cnt - (PTR_W+1)'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // RX FIFO and overflow flag
   always_ff @(posedge raw_clk or posedge reset) begin
      if (reset) begin
         rx_wr       <= '0;
         rx_rd       <= '0;
         rx_cnt      <= '0;
         rx_overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
      end else begin
         if (rx_push_ok) begin
            rx_mem[rx_wr] <= rx_shift;
            rx_wr         <= rx_wr + PTR_W'(1);
         end
         if (rx_pop_ok) rx_rd <= rx_rd + PTR_W'(1);
         case ({rx_push_ok, rx_pop_ok})
            2'b10:   rx_cnt <= rx_cnt + (PTR_W+1)'(1);
            2'b01:   rx_cnt <= rx_cnt - (PTR_W+1)'(1);
            default: rx_cnt <= rx_cnt;
         endcase
         if (ovf_set)             rx_overflow <= 1'b1;
         else if (overflow_clear) rx_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo
//   Directed bench for spi_master_fifo (DIVIDER=2, DEPTH=4). A transaction
//   level model (byte queues plus a cycle index within the current byte)
//   predicts every output each cycle; literal checks pin the model.
module tb_spi_master_fifo;

   localparam int D         = 2;
   localparam int N         = 4;
   localparam int BYTE_CYC  = 16 * D;

   logic       raw_clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_push;
   logic       tx_full;
   logic [7:0] rx_data;
   logic       rx_pop;
   logic       rx_empty;
   logic       rx_overflow;
   logic       overflow_clear;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso_loop;
   logic       miso_level;
   wire        miso_w = miso_loop ? mosi : miso_level;

   int checks = 0;
   int errors = 0;

   spi_master_fifo #(.DIVIDER(D), .DEPTH(N)) dut (
      .raw_clk        (raw_clk),
      .reset          (reset),
      .tx_data        (tx_data),
      .tx_push        (tx_push),
      .tx_full        (tx_full),
      .rx_data        (rx_data),
      .rx_pop         (rx_pop),
      .rx_empty       (rx_empty),
      .rx_overflow    (rx_overflow),
      .overflow_clear (overflow_clear),
      .busy           (busy),
      .sclk           (sclk),
      .mosi           (mosi),
      .miso           (miso_w)
   );

   always #5 raw_clk = ~raw_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [7:0] txq [$];
   logic [7:0] rxq [$];
   logic       m_active = 1'b0;
   int         m_k      = 0;
   logic [7:0] m_cur    = '0;
   logic [7:0] m_acc    = '0;
   logic       m_mosi   = 1'b0;
   logic       m_ovf    = 1'b0;

   always @(posedge raw_clk or posedge reset) begin
      int         tsz, rsz;
      logic       tx_ok, rpop, epush, drop;
      logic [7:0] eb;
      if (reset) begin
         txq.delete();
         rxq.delete();
         m_active = 1'b0;
         m_k      = 0;
         m_acc    = '0;
         m_mosi   = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         tsz   = txq.size();
         rsz   = rxq.size();
         tx_ok = tx_push && (tsz < N);
         rpop  = rx_pop && (rsz > 0);
         epush = 1'b0;
         eb    = '0;
         if (!m_active) begin
            if (tsz > 0) begin
               m_cur    = txq.pop_front();
               m_active = 1'b1;
               m_k      = 0;
               m_mosi   = m_cur[7];
            end
         end else begin
            // miso is captured on the cycle that ends each low half-period
            if ((m_k % (2*D)) == D-1) m_acc = {m_acc[6:0], miso_w};
            if (m_k == BYTE_CYC-1) begin
               m_active = 1'b0;
               epush    = 1'b1;
               eb       = m_acc;
            end else begin
               m_k++;
               m_mosi = m_cur[7 - m_k/(2*D)];
            end
         end
         if (tx_ok) txq.push_back(tx_data);
         if (rpop) void'(rxq.pop_front());
         drop = epush && !((rsz < N) || rpop);
         if (epush && !drop) rxq.push_back(eb);
         if (drop)                m_ovf = 1'b1;
         else if (overflow_clear) m_ovf = 1'b0;
      end
   end

   always @(negedge raw_clk) begin
      chk("sclk", sclk, m_active && (((m_k / D) % 2) == 1));
      chk("mosi", mosi, m_mosi);
      chk("busy", busy, m_active || (txq.size() != 0));
      chk("tx_full", tx_full, txq.size() == N);
      chk("rx_empty", rx_empty, rxq.size() == 0);
      chk("rx_overflow", rx_overflow, m_ovf);
      if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
   end

   // ---------------- bus monitor: bytes seen on mosi ----------------
   logic [7:0] mon_q [$];
   logic [7:0] mon_sh = '0;
   int         mon_n  = 0;

   always @(posedge sclk or posedge reset) begin
      if (reset) begin
         mon_q.delete();
         mon_n = 0;
      end else begin
         mon_sh = {mon_sh[6:0], mosi};
         mon_n++;
         if (mon_n == 8) begin
            mon_q.push_back(mon_sh);
            mon_n = 0;
         end
      end
   end

   function automatic logic [31:0] mon_at(input int i);
      return (mon_q.size() > i) ? {24'd0, mon_q[i]} : 32'hFFFF;
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic push_byte(input logic [7:0] b);
      tx_data = b;
      tx_push = 1'b1;
      @(negedge raw_clk);
      tx_push = 1'b0;
   endtask

   task automatic pop_check(input string nm, input logic [7:0] exp);
      chk(nm, rx_data, exp);
      rx_pop = 1'b1;
      @(negedge raw_clk);
      rx_pop = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) break;
         @(negedge raw_clk);
      end
      chk("idle_timeout", busy, 1'b0);
   endtask

   logic [7:0] vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   initial begin
      int n;
      reset          = 1'b1;
      tx_data        = '0;
      tx_push        = 1'b0;
      rx_pop         = 1'b0;
      overflow_clear = 1'b0;
      miso_loop      = 1'b1;
      miso_level     = 1'b0;

      repeat (3) @(negedge raw_clk);
      chk("rst_tx_full", tx_full, 1'b0);
      chk("rst_rx_empty", rx_empty, 1'b1);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge raw_clk);
      chk("no_start_after_reset", busy, 1'b0);

      // loopback 0xA5, rx_empty falls 32 cycles after the load edge
      push_byte(8'hA5);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge raw_clk);
         n++;
         if (!rx_empty) break;
      end
      chk("t1_push_to_rx", n, 33);
      chk("t1_mosi_bits", mon_at(0), 8'hA5);
      pop_check("t1_rx", 8'hA5);
      wait_idle(100);

      // miso high, two back-to-back bytes
      miso_loop  = 1'b0;
      miso_level = 1'b1;
      mon_q.delete();
      n = 0;
      tx_data = 8'h00;
      tx_push = 1'b1;
      @(negedge raw_clk);
      n += int'(busy);
      tx_data = 8'h3C;
      @(negedge raw_clk);
      tx_push = 1'b0;
      n += int'(busy);
      for (int i = 0; i < 200 && busy; i++) begin
         @(negedge raw_clk);
         n += int'(busy);
      end
      chk("t2_busy_cycles", n, 66);
      chk("t2_mon0", mon_at(0), 8'h00);
      chk("t2_mon1", mon_at(1), 8'h3C);
      pop_check("t2_rx0", 8'hFF);
      pop_check("t2_rx1", 8'hFF);
      chk("t2_rx_empty", rx_empty, 1'b1);

      // six pushes in a row: fifth fills, sixth dropped; RX overflows on fifth byte
      miso_loop = 1'b1;
      mon_q.delete();
      for (int i = 0; i < 6; i++) begin
         tx_data = vals[i];
         tx_push = 1'b1;
         @(negedge raw_clk);
         if (i == 4) chk("t3_full_after_5th", tx_full, 1'b1);
      end
      tx_push = 1'b0;
      wait_idle(400);
      chk("t3_tx_count", mon_q.size(), 5);
      for (int i = 0; i < 5; i++) chk("t3_tx_order", mon_at(i), {24'd0, vals[i]});
      chk("t4_overflow_set", rx_overflow, 1'b1);
      overflow_clear = 1'b1;
      @(negedge raw_clk);
      overflow_clear = 1'b0;
      chk("t4_overflow_clr", rx_overflow, 1'b0);
      for (int i = 0; i < 4; i++) pop_check("t4_rx_order", vals[i]);
      chk("t4_rx_empty", rx_empty, 1'b1);

      // pop on empty, then pop coincident with engine push on a 1-entry FIFO
      rx_pop = 1'b1;
      @(negedge raw_clk);
      rx_pop = 1'b0;
      chk("t5_pop_empty", rx_empty, 1'b1);
      push_byte(8'h5A);
      wait_idle(100);
      chk("t5_head_first", rx_data, 8'h5A);
      push_byte(8'hC3);
      repeat (32) @(negedge raw_clk);
      rx_pop = 1'b1;
      @(negedge raw_clk);
      rx_pop = 1'b0;
      chk("t5_still_one", rx_empty, 1'b0);
      pop_check("t5_new_head", 8'hC3);
      chk("t5_empty_after", rx_empty, 1'b1);
      wait_idle(50);

      // reset in the middle of byte 0x81 (bit 4, sclk high)
      push_byte(8'h81);
      repeat (16) @(negedge raw_clk);
      chk("t6_sclk_before", sclk, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t6_sclk", sclk, 1'b0);
      chk("t6_mosi", mosi, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_rx_empty", rx_empty, 1'b1);
      @(negedge raw_clk);
      @(negedge raw_clk);
      reset = 1'b0;
      repeat (60) @(negedge raw_clk);
      chk("t6_no_rx", rx_empty, 1'b1);
      chk("t6_idle", busy, 1'b0);
      chk("t6_no_bus", mon_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
